// File: rtl/tile_local_arb.sv
// rtl/tile_local_arb.sv - packet-granular round-robin arbiter for the tile local NoC injection port
// A grant is held until TLAST; a two-entry buffer keeps m_TREADY out of the s_TREADY path.
module tile_local_arb #(
  parameter int N_REQ     = 2,
  parameter int BW        = 32,
  parameter int BWB       = BW/8,
  parameter int MAX_BEATS = 64,
  parameter int GW        = $clog2(N_REQ)
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_low,
  input  logic [N_REQ-1:0]     req_mask,
  input  logic                 clear_overrun,
  input  logic [N_REQ-1:0]     s_TVALID,
  input  logic [N_REQ*BW-1:0]  s_TDATA,
  input  logic [N_REQ*BWB-1:0] s_TKEEP,
  input  logic [N_REQ-1:0]     s_TLAST,
  output logic [N_REQ-1:0]     s_TREADY,
  output logic                 m_TVALID,
  output logic [BW-1:0]        m_TDATA,
  output logic [BWB-1:0]       m_TKEEP,
  output logic                 m_TLAST,
  input  logic                 m_TREADY,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 pkt_overrun
);
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [15:0] MAX_CNT  = 16'(MAX_BEATS);
  localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

  state_t         state;
  logic [GW-1:0]  last;
  logic [15:0]    beat_cnt;

  logic [BW-1:0]  buf_data [2];
  logic [BWB-1:0] buf_keep [2];
  logic           buf_last [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     count;

  logic [N_REQ-1:0] cand;
  logic             found;
  logic [GW-1:0]    winner;
  int               idx;

  // Search starts just after the previous grantee so every enabled requester gets a turn.
  always_comb begin
    cand   = s_TVALID & req_mask;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  logic           can_accept;
  logic           push;
  logic           pop;
  logic [BW-1:0]  in_data;
  logic [BWB-1:0] in_keep;
  logic           in_last;

  assign can_accept = (state == LOCKED) && (count != 2'd2);
  assign push       = can_accept && s_TVALID[grant_id];
  assign pop        = (count != 2'd0) && m_TREADY;
  assign in_data    = s_TDATA[int'(grant_id)*BW +: BW];
  assign in_keep    = s_TKEEP[int'(grant_id)*BWB +: BWB];
  assign in_last    = s_TLAST[grant_id];

  always_comb begin
    s_TREADY = '0;
    if (can_accept) s_TREADY[grant_id] = 1'b1;
  end

  assign m_TVALID = (count != 2'd0);
  assign m_TDATA  = buf_data[rd_ptr];
  assign m_TKEEP  = buf_keep[rd_ptr];
  assign m_TLAST  = buf_last[rd_ptr];

  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      state       <= IDLE;
      last        <= GW'(N_REQ - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      pkt_overrun <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_keep[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= LOCKED;
            grant_id <= winner;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        LOCKED: begin
          if (push && in_last) begin
            state <= IDLE;
            last  <= grant_id;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (push && beat_cnt != MAX_CNT) beat_cnt <= beat_cnt + 16'd1;

      // A new overrun takes priority over a clear arriving in the same cycle.
      if (push && !in_last && beat_cnt == LAST_CNT) pkt_overrun <= 1'b1;
      else if (clear_overrun)                          pkt_overrun <= 1'b0;

      if (push) begin
        buf_data[wr_ptr] <= in_data;
        buf_keep[wr_ptr] <= in_keep;
        buf_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_tile_local_arb.sv
// tb/tb_tile_local_arb.sv - self-checking bench for tile_local_arb
// Cycle model with packet queues compared every negedge, plus directed literal checks.
module tb_tile_local_arb;
  localparam int N    = 2;
  localparam int BW   = 32;
  localparam int BWB  = 4;
  localparam int MAXB = 4;
  localparam int GW   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_low = 1'b0;
  logic [N-1:0]     req_mask = '1;
  logic             clear_overrun = 1'b0;
  logic [N-1:0]     s_TVALID;
  logic [N*BW-1:0]  s_TDATA;
  logic [N*BWB-1:0] s_TKEEP;
  logic [N-1:0]     s_TLAST;
  logic [N-1:0]     s_TREADY;
  logic             m_TVALID;
  logic [BW-1:0]    m_TDATA;
  logic [BWB-1:0]   m_TKEEP;
  logic             m_TLAST;
  logic             m_TREADY = 1'b1;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             pkt_overrun;

  tile_local_arb #(.N_REQ(N), .BW(BW), .BWB(BWB), .MAX_BEATS(MAXB), .GW(GW)) dut (
    .clk_line(clk), .clk_line_rst_low(rst_low), .req_mask(req_mask),
    .clear_overrun(clear_overrun), .s_TVALID(s_TVALID), .s_TDATA(s_TDATA),
    .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST), .s_TREADY(s_TREADY),
    .m_TVALID(m_TVALID), .m_TDATA(m_TDATA), .m_TKEEP(m_TKEEP), .m_TLAST(m_TLAST),
    .m_TREADY(m_TREADY), .grant_id(grant_id), .busy(busy), .pkt_overrun(pkt_overrun)
  );

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [BWB-1:0] keep;
    logic           last;
  } beat_t;

  beat_t       src_q [N][$];
  logic [N-1:0] hs = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  int          acc_cyc [$];
  logic [31:0] out_data [$];
  int          out_cyc [$];
  bit          busy_h [4096];
  bit          ovr_h [4096];

  bit    m_on = 1'b0;
  bit    m_locked;
  int    m_gid, m_last, m_cnt;
  bit    m_ovr;
  beat_t m_fq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit pop, acc, set;
    beat_t b;
    if (!rst_low) begin
      m_on = 1'b1; m_locked = 1'b0; m_last = N-1; m_gid = 0; m_cnt = 0; m_ovr = 1'b0;
      m_fq.delete();
      return;
    end
    if (!m_on) return;
    pop = (m_fq.size() != 0) && m_TREADY;
    acc = m_locked && (m_fq.size() < 2) && s_TVALID[m_gid];
    set = 1'b0;
    if (pop) void'(m_fq.pop_front());
    if (m_locked) begin
      if (acc) begin
        b.data = s_TDATA[m_gid*BW +: BW];
        b.keep = s_TKEEP[m_gid*BWB +: BWB];
        b.last = s_TLAST[m_gid];
        m_fq.push_back(b);
        m_cnt++;
        if (m_cnt == MAXB && !b.last) set = 1'b1;
        if (b.last) begin
          m_last = m_gid;
          m_locked = 1'b0;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int r;
        r = (m_last + k) % N;
        if (s_TVALID[r] && req_mask[r]) begin
          m_gid = r; m_locked = 1'b1; m_cnt = 0;
          break;
        end
      end
    end
    m_ovr = set ? 1'b1 : (clear_overrun ? 1'b0 : m_ovr);
  endtask

  // Single compare process: model vs DUT every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", busy, m_locked);
      chk("grant_id", grant_id, m_gid);
      chk("s_TREADY", s_TREADY, (m_locked && m_fq.size() < 2) ? (1 << m_gid) : 0);
      chk("m_TVALID", m_TVALID, m_fq.size() != 0);
      if (m_fq.size() != 0) begin
        chk("m_TDATA", m_TDATA, m_fq[0].data);
        chk("m_TKEEP", m_TKEEP, m_fq[0].keep);
        chk("m_TLAST", m_TLAST, m_fq[0].last);
      end
      chk("pkt_overrun", pkt_overrun, m_ovr);
    end
    for (int i = 0; i < N; i++) if (s_TVALID[i] && s_TREADY[i]) acc_cyc.push_back(cyc);
    hs = s_TVALID & s_TREADY;
    if (m_TVALID && m_TREADY) begin
      out_data.push_back(m_TDATA);
      out_cyc.push_back(cyc);
    end
    busy_h[cyc % 4096] = busy;
    ovr_h[cyc % 4096]  = pkt_overrun;
    model_step();
  end

  // Requester driver: presents the head beat of each queue, pops on handshake.
  initial begin
    s_TVALID = '0; s_TDATA = '0; s_TKEEP = '0; s_TLAST = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (!rst_low) src_q[i].delete();
        else if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          s_TVALID[i] = 1'b1;
          s_TDATA[i*BW +: BW]   = src_q[i][0].data;
          s_TKEEP[i*BWB +: BWB] = src_q[i][0].keep;
          s_TLAST[i] = src_q[i][0].last;
        end else begin
          s_TVALID[i] = 1'b0;
          s_TDATA[i*BW +: BW]   = '0;
          s_TKEEP[i*BWB +: BWB] = '0;
          s_TLAST[i] = 1'b0;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); out_data.delete(); out_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_low = 1'b0;
    wait_cycles(1);
    rst_low = 1'b1;
    clear_logs();
  endtask

  task automatic send(input int r, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = base + 32'(k);
      b.keep = (k == n-1) ? 4'h3 : 4'hF;
      b.last = (k == n-1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_TVALID"}, m_TVALID, 0);
    chk({tag, "_m_TLAST"}, m_TLAST, 0);
    chk({tag, "_m_TDATA"}, m_TDATA, 0);
    chk({tag, "_m_TKEEP"}, m_TKEEP, 0);
    chk({tag, "_s_TREADY"}, s_TREADY, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, pkt_overrun, 0);
  endtask

  initial begin
    int t0, t1, tc;
    // reset state
    do_reset();
    @(negedge clk);
    check_reset_vals("rst");

    // single packet from requester 0
    do_reset();
    t0 = cyc;
    send(0, 32'h10, 4);
    wait_cycles(10);
    chk("t1_nbeats", out_data.size(), 4);
    for (int k = 0; k < 4; k++) chk("t1_data", out_data[k], 32'h10 + k);
    chk("t1_first_lat", out_cyc[0] - t0, 2);
    chk("t1_last_acc", acc_cyc[3] - t0, 4);
    chk("t1_busy_on", busy_h[acc_cyc[3] % 4096], 1);
    chk("t1_busy_off", busy_h[(acc_cyc[3] + 1) % 4096], 0);
    chk("t1_grant", grant_id, 0);

    // round robin with both requesters continuously busy
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send(0, 32'h0000_0100 + 32'(p*16), 2);
      send(1, 32'h1000_0100 + 32'(p*16), 2);
    end
    wait_cycles(30);
    chk("t2_nbeats", out_data.size(), 12);
    for (int k = 0; k < 12; k++) chk("t2_src", out_data[k][28], (k/2) % 2);
    for (int k = 0; k < 11; k++) chk("t2_gap", acc_cyc[k+1] - acc_cyc[k], (k % 2 == 0) ? 1 : 2);

    // backpressure
    do_reset();
    m_TREADY = 1'b0;
    send(0, 32'h20, 8);
    wait_cycles(8);
    chk("t3_acc_held", acc_cyc.size(), 2);
    chk("t3_sready", s_TREADY[0], 0);
    m_TREADY = 1'b1;
    wait_cycles(30);
    chk("t3_nbeats", out_data.size(), 8);
    for (int k = 0; k < 8; k++) chk("t3_data", out_data[k], 32'h20 + k);

    // mask: only requester 1 enabled, then disabled mid-packet
    do_reset();
    req_mask = 2'b10;
    send(0, 32'h30, 2);
    send(1, 32'h1000_0030, 4);
    wait_cycles(3);
    req_mask = 2'b00;
    wait_cycles(15);
    chk("t4_nbeats", out_data.size(), 4);
    for (int k = 0; k < 4; k++) chk("t4_data", out_data[k], 32'h1000_0030 + k);
    chk("t4_busy", busy, 0);
    chk("t4_grant", grant_id, 1);
    chk("t4_q0_untouched", src_q[0].size(), 2);

    // overrun with MAX_BEATS=4
    do_reset();
    req_mask = '1;
    send(0, 32'h40, 6);
    wait_cycles(12);
    chk("t5_nbeats", out_data.size(), 6);
    for (int k = 0; k < 6; k++) chk("t5_data", out_data[k], 32'h40 + k);
    chk("t5_ovr_before", ovr_h[acc_cyc[3] % 4096], 0);
    chk("t5_ovr_after", ovr_h[(acc_cyc[3] + 1) % 4096], 1);
    chk("t5_ovr_sticky", pkt_overrun, 1);
    tc = cyc;
    clear_overrun = 1'b1;
    wait_cycles(1);
    clear_overrun = 1'b0;
    wait_cycles(1);
    chk("t5_clear", ovr_h[(tc + 1) % 4096], 0);
    t1 = cyc;
    send(0, 32'h48, 6);
    wait_cycles(4);
    clear_overrun = 1'b1;
    wait_cycles(1);
    clear_overrun = 1'b0;
    wait_cycles(8);
    chk("t5_acc4", acc_cyc[9] - t1, 4);
    chk("t5_set_wins", ovr_h[(t1 + 5) % 4096], 1);

    // reset mid-packet
    do_reset();
    send(0, 32'h5F, 1);
    wait_cycles(4);
    send(0, 32'h50, 6);
    for (int w = 0; w < 20 && acc_cyc.size() < 4; w++) wait_cycles(1);
    chk("t6_reached_3_beats", acc_cyc.size() >= 4, 1);
    rst_low = 1'b0;
    wait_cycles(1);
    rst_low = 1'b1;
    @(negedge clk);
    check_reset_vals("t6");
    @(posedge clk);
    #1;
    clear_logs();
    send(0, 32'h60, 1);
    send(1, 32'h1000_0060, 1);
    wait_cycles(8);
    chk("t6_nbeats", out_data.size(), 2);
    chk("t6_first", out_data[0], 32'h60);
    chk("t6_second", out_data[1], 32'h1000_0060);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_local_arb.md
# tile_local_arb

Packet-granular round-robin arbiter that shares the tile's single local NoC injection port between `N_REQ` AXI-Stream requesters (accelerator result stream, control-message injector, and others). It sits between the requesters and the switch's local input (`stream_in_local_in_*`) in the `clk_line` domain. A grant is held for a whole packet, so flits of different packets never interleave. A two-entry output buffer decouples the switch's ready signal from the arbitration logic.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `BW`, 32, data width in bits
- `BWB`, BW/8, keep width
- `MAX_BEATS`, 64, beat count at which a packet without TLAST is flagged as overrun (2..65535)
- `GW`, $clog2(N_REQ), grant-index width (derived)

Ports (clock and reset first):
- `clk_line`  in  1  sole clock
- `clk_line_rst_low`  in  1  reset; synchronous, active-low
- `req_mask`  in  N_REQ  1 = requester enabled; quasi-static, driven from the rvControl register
- `clear_overrun`  in  1  single-cycle pulse that clears `pkt_overrun`
- `s_TVALID`  in  N_REQ  per-requester valid
- `s_TDATA`  in  N_REQ*BW  requester i occupies bits [i*BW +: BW]
- `s_TKEEP`  in  N_REQ*BWB  requester i occupies bits [i*BWB +: BWB]
- `s_TLAST`  in  N_REQ  per-requester last
- `s_TREADY`  out  N_REQ  per-requester ready
- `m_TVALID` / `m_TDATA` / `m_TKEEP` / `m_TLAST`  out  1 / BW / BWB / 1  stream to the switch local input
- `m_TREADY`  in  1  switch ready
- `grant_id`  out  GW  current or most recent grantee
- `busy`  out  1  high while in LOCKED
- `pkt_overrun`  out  1  sticky error flag

## Operation
- The FSM has two states, IDLE and LOCKED. The round-robin pointer `last` resets to N_REQ-1.
- **IDLE.**
  - Candidates are all i with `s_TVALID[i] & req_mask[i]`.
  - The winner is the first candidate searched in order last+1, last+2, … (mod N_REQ).
  - If there is a winner, register `grant_id` = winner and go to LOCKED. The beat counter is set to 0.
  - No `s_TREADY` is asserted in IDLE.
- **LOCKED.**
  - `s_TREADY[grant_id]` = (buffer count < 2). All other `s_TREADY` bits are 0.
  - Each accepted beat is written into the buffer and increments the beat counter. The counter saturates at MAX_BEATS.
  - When the counter reaches MAX_BEATS with no TLAST accepted, set `pkt_overrun`. The packet still passes through unmodified; no TLAST is injected.
  - When a beat with TLAST=1 is accepted: set `last` = `grant_id` and go to IDLE on the next cycle.
- **Mask changes.** Clearing `req_mask[grant_id]` during LOCKED does not abort the packet. The mask is evaluated only in IDLE.
- **Requester rules.** A requester may drop `s_TVALID` mid-packet (a bubble). The arbiter keeps waiting in LOCKED indefinitely; there is no timeout abort.
- **Output buffer.**
  - Two-entry FIFO. `m_*` is driven from the head entry; `m_TVALID` = (count ≠ 0).
  - A push and a pop in the same cycle leave the count unchanged.
  - The buffer is never written when full and never read when empty.
- **Overrun flag.** `clear_overrun` clears `pkt_overrun`. If a set and a clear occur in the same cycle, the set wins.
- **Reset.** Reset asserted mid-packet discards the buffer contents and the partial packet, returns to IDLE, and sets `last` = N_REQ-1.
- **Output reset values:**
  - `m_TVALID`=0, `m_TLAST`=0, `m_TDATA`=0, `m_TKEEP`=0
  - `s_TREADY`=0
  - `grant_id`=0, `busy`=0, `pkt_overrun`=0

## Timing
- **Arbitration latency.** Cycle 0: request seen in IDLE. Cycle 1: LOCKED with `s_TREADY` high, first beat accepted. Cycle 2: first beat visible on `m_TVALID`.
- **Throughput.** One beat per cycle while `m_TREADY`=1. `s_TREADY` depends only on registered state (count and FSM); there is no combinational path from `m_TREADY`.
- **Packet gap.** After the TLAST beat is accepted in cycle n, the FSM is in IDLE in cycle n+1 and the next grant is LOCKED in cycle n+2. This gives exactly one dead input cycle between packets.
- **Backpressure.** With `m_TREADY`=0, at most two beats are accepted, then `s_TREADY` drops in the cycle after count reaches 2.
- **Outputs.** `grant_id` and `busy` are registered and change on the IDLE→LOCKED and LOCKED→IDLE edges only.

## Test plan
- **Single packet.** Reset, then N_REQ=2 with requester 0 sending a 4-beat packet (data 0x10..0x13, TLAST on 0x13), `m_TREADY`=1. Required: beats appear in order starting 2 cycles after TVALID rises; `grant_id`=0; `busy` falls one cycle after 0x13 is accepted.
- **Round-robin fairness.** Both requesters continuously send 2-beat packets. Required: output packet sources alternate 0,1,0,1 with no interleaved beats, and exactly one idle input cycle between packets.
- **Backpressure.** Hold `m_TREADY`=0 during an 8-beat packet. Required: exactly 2 beats accepted, `s_TREADY[0]`=0 thereafter. Release `m_TREADY`: all 8 beats delivered in order, none lost or duplicated.
- **Mask.** `req_mask`=2'b10 with both requesters valid: only requester 1 is granted. Clear `req_mask[1]` mid-packet: that packet completes, and no new grant is issued.
- **Overrun.** MAX_BEATS=4 with a 6-beat packet: `pkt_overrun` rises after the 4th beat is accepted and all 6 beats pass unchanged. Assert `clear_overrun` alone: the flag goes low the next cycle. Assert it in the same cycle as a new overrun: the flag stays high.
- **Reset mid-packet.** Assert reset for 1 cycle after 3 beats of a 6-beat packet. Required: all outputs at reset values next cycle, buffer empty, and requester 0 wins the next simultaneous request.
